// File: rtl/hcm_hit_reader_pkg.sv
// hcm_hit_reader_pkg
//   Shared constants and types for the HCM/HIM hit reader: default widths and
//   latencies, the controller state encoding and a small width helper.
package hcm_hit_reader_pkg;

    localparam int HR_ROWINDEXBITS_HCM = 10;
    localparam int HR_ROWINDEXBITS_HIM = 8;
    localparam int HR_MAXHITNBITS      = 3;
    localparam int HR_HITINFOBITS      = 16;
    localparam int HR_NCOLS_HIM        = 128;
    localparam int HR_HCM_READLATENCY  = 4;
    localparam int HR_BRAM_READDELAY   = 2;
    localparam int HR_QUEUESIZE        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HCM_WAIT,
        ST_HIM_WAIT,
        ST_EMIT,
        ST_DONE
    } hr_state_t;

    // Bits needed for a down-counter that is loaded with either latency.
    function automatic int wait_cnt_bits(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hcm_hit_reader_req_fifo.sv
// hcm_hit_reader_req_fifo
//   Synchronous request FIFO, power-of-two depth, registered occupancy count.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   i_push     : write i_data (caller guarantees not full)
//   i_pop      : drop head entry (caller guarantees not empty)
//   o_data     : current head entry
//   o_count    : number of stored entries, 0..DEPTH
module hcm_hit_reader_req_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [PTRW-1:0]        r_wr_ptr;
    logic [PTRW-1:0]        r_rd_ptr;
    logic [$clog2(DEPTH):0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/hcm_hit_reader.sv
// hcm_hit_reader
//   Reads one HCM row per request (hit count + HIM address), fetches the HIM
//   row and streams its packed hits one per beat under valid/ready.
//   Request side : reqValid/reqRow in, reqReady out (FIFO not full)
//   HCM side     : hcmReadRow/hcmRowToRead out; hcmReadFinished,
//                  hcmReadNHits, hcmReadHIMAddress in
//   HIM side     : himReadEnable/himReadAddress out; himDataRead in
//   Hit stream   : hitValid/hitInfo/hitRow/hitLast out, hitReady in
//   Completion   : rowDone pulse with rowNHits/rowError; busy status
//   All outputs are registered; reset is synchronous active-high.
module hcm_hit_reader
    import hcm_hit_reader_pkg::*;
#(
    parameter int ROWINDEXBITS_HCM = HR_ROWINDEXBITS_HCM,
    parameter int ROWINDEXBITS_HIM = HR_ROWINDEXBITS_HIM,
    parameter int MAXHITNBITS      = HR_MAXHITNBITS,
    parameter int HITINFOBITS      = HR_HITINFOBITS,
    parameter int NCOLS_HIM        = HR_NCOLS_HIM,
    parameter int HCM_READLATENCY  = HR_HCM_READLATENCY,
    parameter int BRAM_READDELAY   = HR_BRAM_READDELAY,
    parameter int QUEUESIZE        = HR_QUEUESIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        reqValid,
    input  logic [ROWINDEXBITS_HCM-1:0] reqRow,
    output logic                        reqReady,
    output logic                        hcmReadRow,
    output logic [ROWINDEXBITS_HCM-1:0] hcmRowToRead,
    input  logic                        hcmReadFinished,
    input  logic [MAXHITNBITS-1:0]      hcmReadNHits,
    input  logic [ROWINDEXBITS_HIM-1:0] hcmReadHIMAddress,
    output logic                        himReadEnable,
    output logic [ROWINDEXBITS_HIM-1:0] himReadAddress,
    input  logic [NCOLS_HIM-1:0]        himDataRead,
    output logic                        hitValid,
    output logic [HITINFOBITS-1:0]      hitInfo,
    output logic [ROWINDEXBITS_HCM-1:0] hitRow,
    output logic                        hitLast,
    input  logic                        hitReady,
    output logic                        rowDone,
    output logic [MAXHITNBITS-1:0]      rowNHits,
    output logic                        rowError,
    output logic                        busy
);

    localparam int MAXHITS = NCOLS_HIM / HITINFOBITS;
    localparam int QSB     = $clog2(QUEUESIZE) + 1;
    localparam int KW      = MAXHITNBITS + 1;
    localparam int WCW     = wait_cnt_bits(HCM_READLATENCY, BRAM_READDELAY);

    logic                        w_push;
    logic                        w_pop;
    logic [ROWINDEXBITS_HCM-1:0] w_head;
    logic [QSB-1:0]              w_count;
    logic [QSB-1:0]              w_count_next;
    logic [KW-1:0]               w_k_next;

    hr_state_t                   r_state;
    logic [WCW-1:0]              r_wait;
    logic [KW-1:0]               r_k;
    logic [KW-1:0]               r_n_emit;
    logic                        r_ovf;
    logic [NCOLS_HIM-1:0]        r_buf;
    logic [ROWINDEXBITS_HCM-1:0] r_cur_row;
    logic                        r_req_ready;
    logic                        r_hcm_read_row;
    logic [ROWINDEXBITS_HCM-1:0] r_hcm_row;
    logic                        r_him_read_en;
    logic [ROWINDEXBITS_HIM-1:0] r_him_addr;
    logic                        r_hit_valid;
    logic [HITINFOBITS-1:0]      r_hit_info;
    logic [ROWINDEXBITS_HCM-1:0] r_hit_row;
    logic                        r_hit_last;
    logic                        r_row_done;
    logic [MAXHITNBITS-1:0]      r_row_nhits;
    logic                        r_row_error;
    logic                        r_busy;

    assign w_push   = reqValid && r_req_ready;
    assign w_pop    = (r_state == ST_IDLE) && (w_count != '0);
    assign w_k_next = r_k + 1'b1;

    hcm_hit_reader_req_fifo #(
        .WIDTH (ROWINDEXBITS_HCM),
        .DEPTH (QUEUESIZE)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (reqRow),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_pop) begin
            w_count_next = w_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = w_count - 1'b1;
        end
    end

    // Ready is registered from the next occupancy so it never lags a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_ready <= 1'b1;
        end else begin
            r_req_ready <= (w_count_next < QSB'(QUEUESIZE));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_wait         <= '0;
            r_k            <= '0;
            r_n_emit       <= '0;
            r_ovf          <= 1'b0;
            r_buf          <= '0;
            r_cur_row      <= '0;
            r_hcm_read_row <= 1'b0;
            r_hcm_row      <= '0;
            r_him_read_en  <= 1'b0;
            r_him_addr     <= '0;
            r_hit_valid    <= 1'b0;
            r_hit_info     <= '0;
            r_hit_row      <= '0;
            r_hit_last     <= 1'b0;
            r_row_done     <= 1'b0;
            r_row_nhits    <= '0;
            r_row_error    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_hcm_read_row <= 1'b0;
            r_him_read_en  <= 1'b0;
            r_row_done     <= 1'b0;
            r_busy         <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    // Busy reflects the state/FIFO contents of the next cycle.
                    r_busy <= (w_count != '0) || w_push;
                    if (w_count != '0) begin
                        r_hcm_read_row <= 1'b1;
                        r_hcm_row      <= w_head;
                        r_cur_row      <= w_head;
                        r_wait         <= WCW'(HCM_READLATENCY);
                        r_state        <= ST_HCM_WAIT;
                    end
                end

                ST_HCM_WAIT: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end else if (!hcmReadFinished) begin
                        r_row_done  <= 1'b1;
                        r_row_nhits <= '0;
                        r_row_error <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (hcmReadNHits == '0) begin
                        r_row_done  <= 1'b1;
                        r_row_nhits <= '0;
                        r_row_error <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_him_read_en <= 1'b1;
                        r_him_addr    <= hcmReadHIMAddress;
                        r_wait        <= WCW'(BRAM_READDELAY);
                        if ({1'b0, hcmReadNHits} > KW'(MAXHITS)) begin
                            r_n_emit <= KW'(MAXHITS);
                            r_ovf    <= 1'b1;
                        end else begin
                            r_n_emit <= {1'b0, hcmReadNHits};
                            r_ovf    <= 1'b0;
                        end
                        r_state <= ST_HIM_WAIT;
                    end
                end

                ST_HIM_WAIT: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end else begin
                        // First beat is taken straight from the BRAM output.
                        r_buf       <= himDataRead;
                        r_k         <= '0;
                        r_hit_valid <= 1'b1;
                        r_hit_info  <= himDataRead[HITINFOBITS-1:0];
                        r_hit_row   <= r_cur_row;
                        r_hit_last  <= (r_n_emit == KW'(1));
                        r_state     <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (hitReady) begin
                        if (r_hit_last) begin
                            r_hit_valid <= 1'b0;
                            r_hit_last  <= 1'b0;
                            r_row_done  <= 1'b1;
                            r_row_nhits <= r_n_emit[MAXHITNBITS-1:0];
                            r_row_error <= r_ovf;
                            r_state     <= ST_DONE;
                        end else begin
                            r_k        <= w_k_next;
                            r_hit_info <= r_buf[w_k_next*HITINFOBITS +: HITINFOBITS];
                            r_hit_last <= ((w_k_next + 1'b1) == r_n_emit);
                        end
                    end
                end

                ST_DONE: begin
                    r_busy  <= (w_count != '0) || w_push;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign reqReady       = r_req_ready;
    assign hcmReadRow     = r_hcm_read_row;
    assign hcmRowToRead   = r_hcm_row;
    assign himReadEnable  = r_him_read_en;
    assign himReadAddress = r_him_addr;
    assign hitValid       = r_hit_valid;
    assign hitInfo        = r_hit_info;
    assign hitRow         = r_hit_row;
    assign hitLast        = r_hit_last;
    assign rowDone        = r_row_done;
    assign rowNHits       = r_row_nhits;
    assign rowError       = r_row_error;
    assign busy           = r_busy;

endmodule

// File: tb/tb_hcm_hit_reader.sv
module tb_hcm_hit_reader;

    localparam int RH      = 10;
    localparam int RM      = 8;
    localparam int NB      = 3;
    localparam int HB      = 16;
    localparam int NC      = 64;
    localparam int LAT     = 4;
    localparam int DLY     = 2;
    localparam int QS      = 4;
    localparam int MAXHITS = NC / HB;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic [RH-1:0] reqRow;
    logic          reqReady;
    logic          hcmReadRow;
    logic [RH-1:0] hcmRowToRead;
    logic          hcmReadFinished;
    logic [NB-1:0] hcmReadNHits;
    logic [RM-1:0] hcmReadHIMAddress;
    logic          himReadEnable;
    logic [RM-1:0] himReadAddress;
    logic [NC-1:0] himDataRead;
    logic          hitValid;
    logic [HB-1:0] hitInfo;
    logic [RH-1:0] hitRow;
    logic          hitLast;
    logic          hitReady;
    logic          rowDone;
    logic [NB-1:0] rowNHits;
    logic          rowError;
    logic          busy;

    hcm_hit_reader #(
        .ROWINDEXBITS_HCM (RH),
        .ROWINDEXBITS_HIM (RM),
        .MAXHITNBITS      (NB),
        .HITINFOBITS      (HB),
        .NCOLS_HIM        (NC),
        .HCM_READLATENCY  (LAT),
        .BRAM_READDELAY   (DLY),
        .QUEUESIZE        (QS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .reqValid          (reqValid),
        .reqRow            (reqRow),
        .reqReady          (reqReady),
        .hcmReadRow        (hcmReadRow),
        .hcmRowToRead      (hcmRowToRead),
        .hcmReadFinished   (hcmReadFinished),
        .hcmReadNHits      (hcmReadNHits),
        .hcmReadHIMAddress (hcmReadHIMAddress),
        .himReadEnable     (himReadEnable),
        .himReadAddress    (himReadAddress),
        .himDataRead       (himDataRead),
        .hitValid          (hitValid),
        .hitInfo           (hitInfo),
        .hitRow            (hitRow),
        .hitLast           (hitLast),
        .hitReady          (hitReady),
        .rowDone           (rowDone),
        .rowNHits          (rowNHits),
        .rowError          (rowError),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // HCM / HIM memory models driven from lookup tables
    logic          hcm_fin  [1024];
    logic [NB-1:0] hcm_nh   [1024];
    logic [RM-1:0] hcm_addr [1024];
    logic [NC-1:0] him_mem  [256];
    logic [RH-1:0] hcm_row_q = '0;
    logic [RM-1:0] him_addr_q = '0;

    always @(posedge clk) begin
        if (hcmReadRow) hcm_row_q <= hcmRowToRead;
        if (himReadEnable) him_addr_q <= himReadAddress;
    end
    assign hcmReadFinished   = hcm_fin[hcm_row_q];
    assign hcmReadNHits      = hcm_nh[hcm_row_q];
    assign hcmReadHIMAddress = hcm_addr[hcm_row_q];
    assign himDataRead       = him_mem[him_addr_q];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [HB-1:0] info;
        logic [RH-1:0] row;
        logic          last;
    } beat_t;
    typedef struct packed {
        logic [NB-1:0] nh;
        logic          err;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int    exp_him = 0;
    int    him_cnt = 0;

    task automatic expect_row(input int row);
        int            n;
        logic [NC-1:0] data;
        done_t         d;
        beat_t         b;
        if (!hcm_fin[row]) begin
            d.nh = '0; d.err = 1'b1;
        end else if (hcm_nh[row] == '0) begin
            d.nh = '0; d.err = 1'b0;
        end else begin
            n = (int'(hcm_nh[row]) > MAXHITS) ? MAXHITS : int'(hcm_nh[row]);
            d.nh  = NB'(n);
            d.err = (int'(hcm_nh[row]) > MAXHITS);
            exp_him++;
            data = him_mem[hcm_addr[row]];
            for (int i = 0; i < n; i++) begin
                b.info = data[i*HB +: HB];
                b.row  = RH'(row);
                b.last = (i == n - 1);
                beat_q.push_back(b);
            end
        end
        done_q.push_back(d);
    endtask

    // Monitor: scoreboard compare plus event timestamps
    int    last_hcm_cyc = -1, last_him_cyc = -1, first_hv_cyc = -1;
    int    last_beat_cyc = -1, last_done_cyc = -1;
    int    last_him_addr = -1;
    bit    prev_hv = 0, prev_stall = 0;
    beat_t hold;

    always @(negedge clk) begin
        beat_t bq;
        done_t dq;
        if (!reset) begin
            if (hcmReadRow) last_hcm_cyc = cyc;
            if (himReadEnable) begin
                him_cnt++;
                last_him_cyc  = cyc;
                last_him_addr = int'(himReadAddress);
            end
            if (hitValid && !prev_hv) first_hv_cyc = cyc;
            if (hitValid && prev_stall) begin
                check("hold_info", hitInfo, hold.info);
                check("hold_row",  hitRow,  hold.row);
                check("hold_last", hitLast, hold.last);
            end
            if (hitValid && hitReady) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    bq = beat_q.pop_front();
                    check("beat_info", hitInfo, bq.info);
                    check("beat_row",  hitRow,  bq.row);
                    check("beat_last", hitLast, bq.last);
                    if (hitLast) last_beat_cyc = cyc;
                end
            end
            prev_stall = hitValid && !hitReady;
            hold.info  = hitInfo;
            hold.row   = hitRow;
            hold.last  = hitLast;
            prev_hv    = hitValid;
            if (rowDone) begin
                last_done_cyc = cyc;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    dq = done_q.pop_front();
                    check("done_nhits", rowNHits, dq.nh);
                    check("done_error", rowError, dq.err);
                end
            end
        end else begin
            prev_stall = 0;
            prev_hv    = 0;
        end
    end

    task automatic send_req(input int row, output int t);
        bit ok;
        ok = 0;
        t  = -1;
        reqValid = 1'b1;
        reqRow   = RH'(row);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (reqReady) begin
                ok = 1;
                t  = cyc;
                expect_row(row);
            end
        end
        if (!ok) check("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done_q.size() == 0 && !busy) ok = 1;
        end
        check({tag, "_idle"}, 32'(ok), 1);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit_valid(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (hitValid) ok = 1;
        end
        check({tag, "_hitvalid_seen"}, 32'(ok), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int him_before;

        for (int i = 0; i < 1024; i++) begin
            hcm_fin[i] = 1'b0; hcm_nh[i] = '0; hcm_addr[i] = '0;
        end
        for (int i = 0; i < 256; i++) him_mem[i] = '0;

        hcm_fin[5]  = 1; hcm_nh[5]  = 3; hcm_addr[5]  = 7;
        him_mem[7]  = 64'h0000_00C3_00B2_00A1;
        hcm_fin[9]  = 1; hcm_nh[9]  = 0; hcm_addr[9]  = 8;
        hcm_fin[12] = 1; hcm_nh[12] = 2; hcm_addr[12] = 3;
        him_mem[3]  = 64'h0000_0000_1234_5678;
        hcm_fin[20] = 0; hcm_nh[20] = 5; hcm_addr[20] = 9;
        hcm_fin[33] = 1; hcm_nh[33] = 6; hcm_addr[33] = 10;
        him_mem[10] = 64'h4444_3333_2222_1111;
        hcm_fin[40] = 1; hcm_nh[40] = 4; hcm_addr[40] = 11;
        him_mem[11] = {$urandom, $urandom};
        hcm_fin[41] = 1; hcm_nh[41] = 1; hcm_addr[41] = 12;
        him_mem[12] = {$urandom, $urandom};
        hcm_fin[50] = 1; hcm_nh[50] = 3; hcm_addr[50] = 13;
        him_mem[13] = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            hcm_fin[51+i]  = 1;
            hcm_addr[51+i] = RM'(20 + i);
            him_mem[20+i]  = {$urandom, $urandom};
        end
        hcm_nh[51] = 1; hcm_nh[52] = 2; hcm_nh[53] = 0; hcm_nh[54] = 2; hcm_nh[55] = 1;
        hcm_fin[60] = 1; hcm_nh[60] = 4; hcm_addr[60] = 30;
        him_mem[30] = 64'hDDDD_CCCC_BBBB_AAAA;

        reset = 1'b1; reqValid = 1'b0; reqRow = '0; hitReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hitValid", hitValid, 0);
        check("rst_busy", busy, 0);
        check("rst_reqReady", reqReady, 1);
        check("rst_hcmReadRow", hcmReadRow, 0);
        check("rst_himReadEnable", himReadEnable, 0);
        check("rst_rowDone", rowDone, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single row, three hits, latency profile
        send_req(5, t);
        wait_idle("row5");
        check("row5_hcm_lat", last_hcm_cyc - t, 2);
        check("row5_him_lat", last_him_cyc - t, 3 + LAT);
        check("row5_him_addr", last_him_addr, 7);
        check("row5_first_hit_lat", first_hv_cyc - t, 4 + LAT + DLY);
        check("row5_done_after_last", last_done_cyc - last_beat_cyc, 1);

        // Zero hits: no HIM access, done straight from the HCM sample
        him_before = him_cnt;
        send_req(9, t);
        wait_idle("row9");
        check("row9_no_him", him_cnt - him_before, 0);
        check("row9_done_lat", last_done_cyc - t, 3 + LAT);

        // Backpressure on first beat
        hitReady = 1'b0;
        send_req(12, t);
        wait_hit_valid("bp");
        repeat (3) begin @(posedge clk); #1; end
        hitReady = 1'b1;
        wait_idle("bp");

        // HCM not finished at sample point
        him_before = him_cnt;
        send_req(20, t);
        wait_idle("err");
        check("err_no_him", him_cnt - him_before, 0);

        // Count overflow, exactly MAXHITS, single hit
        send_req(33, t);
        wait_idle("ovf");
        send_req(40, t);
        wait_idle("max");
        send_req(41, t);
        wait_idle("one");

        // Burst while the controller is busy with row 50
        send_req(50, t);
        for (int i = 0; i < 4; i++) send_req(51 + i, t);
        @(negedge clk);
        check("burst_ready_low", reqReady, 0);
        @(posedge clk); #1;
        send_req(55, t);
        wait_idle("burst");

        // Reset during EMIT of hit 2 of 4
        hitReady = 1'b0;
        send_req(60, t);
        wait_hit_valid("rst_emit");
        @(posedge clk); #1;
        hitReady = 1'b1;
        @(posedge clk); #1;
        hitReady = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_hitValid", hitValid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_reqReady", reqReady, 1);
        check("midrst_rowDone", rowDone, 0);
        check("midrst_beats_consumed", beat_q.size(), 3);
        beat_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        hitReady = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Recovery after reset
        send_req(5, t);
        wait_idle("recover");
        check("recover_first_hit_lat", first_hv_cyc - t, 4 + LAT + DLY);

        check("him_strobe_total", him_cnt, exp_him);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
